// File: rtl/famiclone_pkg.sv
// Shared types and sizing helpers for the famiclone console detector.
package famiclone_pkg;

  typedef enum logic [1:0] {GROUND, OBSERVE, DECIDED} state_e;

  // Bits needed to hold 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/famiclone_detect_if.sv
// PPU-side sense inputs, software re-arm and verdict outputs of the detector.
interface famiclone_detect_if;
  logic ppu_rd_in;
  logic ppu_a13;
  logic ppu_not_a13;
  logic rearm;
  logic ground_en;
  logic done;
  logic new_dendy;
  logic timed_out;

  modport master (output ppu_rd_in, ppu_a13, ppu_not_a13, rearm,
                  input  ground_en, done, new_dendy, timed_out);
  modport slave  (input  ppu_rd_in, ppu_a13, ppu_not_a13, rearm,
                  output ground_en, done, new_dendy, timed_out);
endinterface

// File: rtl/sync_bus.sv
// SYNC_STAGES-deep synchroniser for the three asynchronous PPU sense lines.
module sync_bus #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       m2,
  input  logic       rst_n,
  input  logic [2:0] d,
  output logic [2:0] q
);
  logic [SYNC_STAGES-1:0][2:0] sync_q;

  always_ff @(posedge m2 or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], d};

  assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/famiclone_detect.sv
// Power-on console detector: grounds CIRAM /CE and /A13, then classifies the console
// from PPU reads. FAMICLONE_DETECT_RETRY_EN grants one extra attempt after a timeout.
module famiclone_detect
  import famiclone_pkg::*;
#(
  parameter int INIT_CYCLES     = 15,
  parameter int MIN_PHASE       = 3,
  parameter int MISMATCH_THRESH = 1,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int SYNC_STAGES     = 2
) (
  input logic               m2,
  input logic               rst_n,
  famiclone_detect_if.slave bus
);
  localparam int GW = cnt_w(INIT_CYCLES);
  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  localparam int PW = cnt_w(MIN_PHASE);
  localparam int MW = cnt_w(MISMATCH_THRESH);

  logic [2:0] ppu_s;
  logic       rd_s, a13_s, na13_s;

  sync_bus #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .m2    (m2),
    .rst_n (rst_n),
    .d     ({bus.ppu_rd_in, bus.ppu_a13, bus.ppu_not_a13}),
    .q     (ppu_s)
  );
  assign rd_s   = ppu_s[2];
  assign a13_s  = ppu_s[1];
  assign na13_s = ppu_s[0];

  state_e  state_q, state_d;
  logic [GW-1:0] gnd_q, gnd_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [PW-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [MW-1:0] mis_q, mis_d;
  logic    ground_en_q, done_q, done_d, nd_q, nd_d, tof_q, tof_d;
  logic    samp, tmo_hit, retry_ok;

`ifdef FAMICLONE_DETECT_RETRY_EN
  logic retry_q;
  always_ff @(posedge m2 or negedge rst_n)
    if (!rst_n)         retry_q <= 1'b0;
    else if (bus.rearm) retry_q <= 1'b0;
    else if (tmo_hit)   retry_q <= 1'b1;
  assign retry_ok = !retry_q;
`else
  assign retry_ok = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnd_d   = gnd_q;
    tmo_d   = tmo_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    mis_d   = mis_q;
    done_d  = done_q;
    nd_d    = nd_q;
    tof_d   = tof_q;
    samp    = 1'b0;
    tmo_hit = 1'b0;
    case (state_q)
      GROUND: begin
        if (gnd_q == GW'(INIT_CYCLES - 1)) begin
          state_d = OBSERVE;
          gnd_d   = '0;
        end else begin
          gnd_d = gnd_q + 1'b1;
        end
      end
      OBSERVE: begin
        samp = !rd_s;
        if (samp && !a13_s && lo_q != PW'(MIN_PHASE)) lo_d = lo_q + 1'b1;
        if (samp &&  a13_s && hi_q != PW'(MIN_PHASE)) hi_d = hi_q + 1'b1;
        if (samp && (a13_s == na13_s) && mis_q != MW'(MISMATCH_THRESH)) mis_d = mis_q + 1'b1;
        // Completion is judged on post-update counts, so it wins over a same-cycle timeout.
        if (lo_d == PW'(MIN_PHASE) && hi_d == PW'(MIN_PHASE)) begin
          state_d = DECIDED;
          done_d  = 1'b1;
          nd_d    = (mis_d == MW'(MISMATCH_THRESH));
          tof_d   = 1'b0;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo_hit = 1'b1;
          if (retry_ok) begin
            state_d = GROUND;
            tmo_d   = '0;
            lo_d    = '0;
            hi_d    = '0;
            mis_d   = '0;
          end else begin
            state_d = DECIDED;
            done_d  = 1'b1;
            nd_d    = 1'b0;
            tof_d   = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (bus.rearm) begin
      state_d = GROUND;
      gnd_d   = '0;
      tmo_d   = '0;
      lo_d    = '0;
      hi_d    = '0;
      mis_d   = '0;
      done_d  = 1'b0;
      nd_d    = 1'b0;
      tof_d   = 1'b0;
    end
  end

  always_ff @(posedge m2 or negedge rst_n)
    if (!rst_n) begin
      state_q     <= GROUND;
      gnd_q       <= '0;
      tmo_q       <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      mis_q       <= '0;
      ground_en_q <= 1'b1;
      done_q      <= 1'b0;
      nd_q        <= 1'b0;
      tof_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnd_q       <= gnd_d;
      tmo_q       <= tmo_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      mis_q       <= mis_d;
      ground_en_q <= (state_d == GROUND);
      done_q      <= done_d;
      nd_q        <= nd_d;
      tof_q       <= tof_d;
    end

  assign bus.ground_en = ground_en_q;
  assign bus.done      = done_q;
  assign bus.new_dendy = nd_q;
  assign bus.timed_out = tof_q;
endmodule
